// File: rtl/usb4_ll_pkg.sv
// Logical-layer ordered-set constants shared by the lane receive detector and the data-bus transmit path.
// Byte values, OS report codes, set length and detector FSM encodings.
package usb4_ll_pkg;

  localparam logic [3:0] OS_NONE  = 4'd0;
  localparam logic [3:0] OS_SLOS1 = 4'd1;
  localparam logic [3:0] OS_SLOS2 = 4'd2;
  localparam logic [3:0] OS_TS1   = 4'd3;
  localparam logic [3:0] OS_TS2   = 4'd4;

  localparam logic [7:0] SYNC_BYTE  = 8'hF0;
  localparam logic [7:0] TYPE_SLOS1 = 8'h33;
  localparam logic [7:0] TYPE_SLOS2 = 8'h3C;
  localparam logic [7:0] TYPE_TS1   = 8'h1E;
  localparam logic [7:0] TYPE_TS2   = 8'h2D;
  localparam logic [7:0] FILL_BYTE  = 8'hAA;

  localparam int unsigned OS_LEN = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HUNT    = 2'd1,
    ST_COLLECT = 2'd2
  } os_state_e;

  // Unknown type bytes map to OS_NONE, which the detector treats as malformed.
  function automatic logic [3:0] type_to_code(input logic [7:0] type_byte);
    case (type_byte)
      TYPE_SLOS1: return OS_SLOS1;
      TYPE_SLOS2: return OS_SLOS2;
      TYPE_TS1:   return OS_TS1;
      TYPE_TS2:   return OS_TS2;
      default:    return OS_NONE;
    endcase
  endfunction

endpackage

// File: rtl/lane_os_detector.sv
// Per-lane receive ordered-set detector: qualifies SLOS1/SLOS2/TS1/TS2 after MATCH_COUNT identical sets.
// Pulses/status register one cycle after the deciding byte; byte_valid low simply stalls the FSM.
module lane_os_detector
  import usb4_ll_pkg::*;
#(
  parameter int unsigned MATCH_COUNT = 2
) (
  input  logic       fsm_clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       byte_valid,
  input  logic [7:0] lane_rx,
  output logic [3:0] os_in,
  output logic       os_valid,
  output logic [1:0] lane_num,
  output logic       os_err,
  output logic       locked
);

  localparam int unsigned   CW        = $clog2(MATCH_COUNT + 1);
  localparam logic [CW-1:0] MATCH_MAX = CW'(MATCH_COUNT);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [3:0]    LAST_IDX  = 4'(OS_LEN - 1);

  os_state_e     state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [7:0]    xor_q, xor_d;
  logic [3:0]    code_q, code_d;
  logic [1:0]    lane_q, lane_d;
  logic [5:0]    id_q, id_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    os_in_q, os_in_d;
  logic [1:0]    lane_num_q, lane_num_d;
  logic          os_valid_q, os_valid_d;
  logic          os_err_q, os_err_d;
  logic          locked_q, locked_d;

  logic          byte_ok;
  logic [5:0]    new_id;
  logic [CW-1:0] cnt_nxt;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    xor_d      = xor_q;
    code_d     = code_q;
    lane_d     = lane_q;
    id_d       = id_q;
    cnt_d      = cnt_q;
    os_in_d    = os_in_q;
    lane_num_d = lane_num_q;
    os_valid_d = 1'b0;
    os_err_d   = 1'b0;
    locked_d   = locked_q;
    byte_ok    = 1'b1;
    new_id     = '0;
    cnt_nxt    = '0;

    if (!enable) begin
      state_d  = ST_IDLE;
      idx_d    = '0;
      cnt_d    = '0;
      locked_d = 1'b0;
      os_in_d  = OS_NONE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_HUNT;
        ST_HUNT: begin
          if (byte_valid && lane_rx == SYNC_BYTE) begin
            state_d = ST_COLLECT;
            idx_d   = 4'd1;
            xor_d   = '0;
          end
        end
        ST_COLLECT: begin
          if (byte_valid) begin
            case (idx_q)
              4'd1: begin
                code_d  = type_to_code(lane_rx);
                byte_ok = (code_d != OS_NONE);
              end
              4'd2: begin
                lane_d  = lane_rx[1:0];
                byte_ok = (lane_rx[7:2] == 6'd0);
              end
              LAST_IDX: byte_ok = (lane_rx == xor_q);
              default:  byte_ok = (lane_rx == FILL_BYTE);
            endcase
            xor_d = xor_q ^ lane_rx;
            idx_d = idx_q + 4'd1;

            if (!byte_ok) begin
              os_err_d = 1'b1;
              cnt_d    = '0;
              locked_d = 1'b0;
              // A stray SYNC inside a set is taken as the start of the next one.
              if (lane_rx == SYNC_BYTE) begin
                idx_d = 4'd1;
                xor_d = '0;
              end else begin
                state_d = ST_HUNT;
                idx_d   = '0;
              end
            end else if (idx_q == LAST_IDX) begin
              new_id[5:2] = code_q;
              new_id[1:0] = (code_q == OS_SLOS1 || code_q == OS_SLOS2) ? 2'b00 : lane_q;
              if (new_id == id_q) begin
                cnt_nxt = (cnt_q == MATCH_MAX) ? cnt_q : cnt_q + CNT_ONE;
              end else begin
                cnt_nxt = CNT_ONE;
              end
              id_d     = new_id;
              cnt_d    = cnt_nxt;
              locked_d = (cnt_nxt == MATCH_MAX);
              if (cnt_nxt == MATCH_MAX) begin
                os_in_d    = code_q;
                lane_num_d = new_id[1:0];
                os_valid_d = 1'b1;
              end
              state_d = ST_HUNT;
              idx_d   = '0;
            end
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  always_ff @(posedge fsm_clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_HUNT;
      idx_q      <= '0;
      xor_q      <= '0;
      code_q     <= OS_NONE;
      lane_q     <= '0;
      id_q       <= '0;
      cnt_q      <= '0;
      os_in_q    <= OS_NONE;
      lane_num_q <= '0;
      os_valid_q <= 1'b0;
      os_err_q   <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      xor_q      <= xor_d;
      code_q     <= code_d;
      lane_q     <= lane_d;
      id_q       <= id_d;
      cnt_q      <= cnt_d;
      os_in_q    <= os_in_d;
      lane_num_q <= lane_num_d;
      os_valid_q <= os_valid_d;
      os_err_q   <= os_err_d;
      locked_q   <= locked_d;
    end
  end

  assign os_in    = os_in_q;
  assign lane_num = lane_num_q;
  assign os_valid = os_valid_q;
  assign os_err   = os_err_q;
  assign locked   = locked_q;

endmodule

// File: doc/lane_os_detector.md
# lane_os_detector

Receive-side ordered-set detector for one USB4 lane of the logical layer. Consumes the decoded byte stream of a lane (after the decoding/deskew path, before the data bus) and recognises SLOS1, SLOS2, TS1 and TS2 ordered sets. Reports each qualified set to the control FSM on a 4-bit `os_in` code. It is the counterpart of the data-bus ordered-set transmit path; two instances, one per lane, are used.

## Interface
- `MATCH_COUNT`, default 2: number of consecutive identical valid sets required before reporting; legal range 1..15.
- `fsm_clk`  in  1  logical-layer FSM clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `enable`  in  1  detector active (driven by lane-receive enable); low forces IDLE.
- `byte_valid`  in  1  `lane_rx` carries a new byte this cycle.
- `lane_rx`  in  8  received lane byte.
- `os_in`  out  4  code of the last qualified set: 0 NONE, 1 SLOS1, 2 SLOS2, 3 TS1, 4 TS2.
- `os_valid`  out  1  one-cycle pulse per qualified set.
- `lane_num`  out  2  lane-number field of the last qualified TS1/TS2.
- `os_err`  out  1  one-cycle pulse on a malformed set.
- `locked`  out  1  high while the match count has reached `MATCH_COUNT`.

## Operation
- Set format, 16 bytes:
  - B0 = SYNC 8'hF0.
  - B1 = type: 8'h33 SLOS1, 8'h3C SLOS2, 8'h1E TS1, 8'h2D TS2.
  - B2 = info: bits[1:0] lane number; bits[7:2] must be 0.
  - B3..B14 = FILL 8'hAA.
  - B15 = XOR of B1..B14.
- Only cycles with `byte_valid`=1 advance the FSM; stalls of any length are allowed.
- States:
  - IDLE: entered when `enable`=0. Clears the byte index, match count, and `locked`, and sets `os_in` to NONE.
  - HUNT: waits for SYNC. When SYNC is seen: byte index = 1, go to COLLECT.
  - COLLECT: checks each byte against the format and accumulates the XOR over B1..B15.
- Mismatch in COLLECT (unknown type, nonzero info bits[7:2], wrong FILL, bad checksum):
  - pulse `os_err`, clear the match count and `locked`;
  - if the offending byte equals SYNC, go to COLLECT with index 1 (resync); otherwise go to HUNT.
  - `os_in` and `lane_num` hold their previous values.
- Valid B15, identity = {type, lane number}:
  - identity equals the previous valid set's identity: match count + 1, saturating at `MATCH_COUNT`;
  - otherwise: match count = 1 and the new identity is stored.
  - After the update, if match count == `MATCH_COUNT`: `os_in` ← code, `lane_num` ← field (0 for SLOS), `os_valid` pulses, `locked` = 1.
  - The FSM returns to HUNT.
- Once locked, every further identical set pulses `os_valid` again.
- A differing valid set drops `locked` and restarts qualification. It does not flag `os_err`.
- SLOS sets ignore the info lane field in the identity comparison.

## Timing
- Reset values: `os_in`=0, `os_valid`=0, `os_err`=0, `lane_num`=0, `locked`=0; state HUNT, byte index 0, match count 0.
- Latency: `os_valid`/`os_err` rise in the cycle after the deciding byte is sampled, and last exactly one cycle.
- `os_in`, `lane_num` and `locked` update in that same cycle and are registered.
- `enable` falling mid-set: IDLE on the next edge, no `os_err`, partial set discarded.
- `enable` rising: go to HUNT on the next edge. The byte present in that cycle is ignored.
- Reset asserted mid-set: immediate return to reset values, independent of the clock.
- Back-to-back sets with no gap between B15 and the next B0 must be detected. HUNT accepts SYNC in the cycle immediately after B15.

## Structure
- Shared package `usb4_ll_pkg` holds:
  - OS code constants (NONE/SLOS1/SLOS2/TS1/TS2);
  - SYNC, type, and FILL byte constants;
  - the set length (16);
  - FSM state encodings.
- The data-bus transmit path uses the same constants.
- Single module, no sub-module. Checksum accumulator, byte index (4 bits) and match counter ($clog2(MATCH_COUNT+1) bits) are inline.

## Test plan
- Two consecutive TS1 sets, lane field 2'b01, `MATCH_COUNT`=2: no pulse after the first; after the second B15 → `os_valid` pulses once, `os_in`=3, `lane_num`=1, `locked`=1.
- TS1 sets with B15 corrupted (XOR ^ 8'h01): `os_err` pulses one cycle after B15, match count cleared. Then two good TS2 sets, lane 0 → `os_in`=4.
- SLOS1 ×2 then TS1 ×1: `os_in`=1 reported and `locked`=1; after the TS1 set, `locked`=0, `os_in` stays 1, no `os_err`.
- FILL byte replaced by 8'hF0 at B7, followed by a complete set: `os_err` pulses, resync counts that byte as B0, and the next valid set is accepted with count 1.
- `byte_valid` toggled randomly (50%) during two SLOS2 sets: `os_in`=2 after the second set, exactly one `os_valid` pulse.
- `enable` dropped at B9 of a locked TS2 stream: no `os_err`, `os_in`=0 and `locked`=0 next cycle. Reset pulse mid-set: all outputs at reset values immediately.
